dynode_trigger_cfd: RTL

DYNODE_TRIGGER_CFD -- requirements
Module: dynode_trigger_cfd

---
 rtl/dynode_trigger_cfd.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dynode_trigger_cfd.sv
// Constant-fraction trigger for dynode pulses: peak detect on a sample history,
// backward search for the pickoff crossing, 6-bit restoring divide for fine time.
module dynode_trigger_cfd #(
    parameter int          W          = 8,
    parameter int          DEPTH      = 16,
    parameter int          FRAC_SHIFT = 1,
    parameter logic [15:0] BASE_ADDR  = 16'h0E00
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [33:0]              ibus,
    output logic [15:0]              obus,
    input  logic [W-1:0]             data_in,
    output logic                     single,
    output logic [5:0]               offset,
    output logic [$clog2(DEPTH)-1:0] coarse,
    output logic [W-1:0]             energy,
    output logic                     pileup,
    output logic                     busy
);
    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SEARCH  = 3'd1;
    localparam logic [2:0] DIVIDE  = 3'd2;
    localparam logic [2:0] EMIT    = 3'd3;
    localparam logic [2:0] HOLDOFF = 3'd4;

    // ibus: [33] write strobe, [32] read strobe, [31:16] address, [15:0] write data
    logic        bus_wr, bus_rd;
    logic [15:0] bus_addr, bus_wdata, reg_off;
    assign bus_wr    = ibus[33];
    assign bus_rd    = ibus[32];
    assign bus_addr  = ibus[31:16];
    assign bus_wdata = ibus[15:0];
    assign reg_off   = bus_addr - BASE_ADDR;

    // Assertion is immediate, release is aligned to clk through two flops
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [W-1:0]  thresh_low, thresh_high;
    logic [7:0]    holdoff;
    logic [15:0]   trig_cnt, pileup_cnt, reject_cnt;

    logic [2:0]    state;
    logic [W-1:0]  hist [DEPTH];
    logic [W-1:0]  snap [DEPTH];
    logic [W-1:0]  peak_val, level, den;
    logic [W+5:0]  rem;
    logic [5:0]    quo;
    logic [2:0]    dcnt;
    logic [CW-1:0] idx, coarse_lat;
    logic [7:0]    hold_lat, hcnt;
    logic          flag;

    logic          peak;
    logic [CW-1:0] idx_next;
    logic [W+5:0]  rem_shift;
    logic          rem_ge;

    assign peak      = (hist[1] > thresh_low) && (hist[1] >= hist[2]) && (hist[1] > hist[0]);
    assign idx_next  = idx + 1'b1;
    assign rem_shift = {rem[W+4:0], 1'b0};
    assign rem_ge    = rem_shift >= {6'd0, den};
    assign busy      = state != IDLE;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_low  <= W'(16);
            thresh_high <= '1;
            holdoff     <= 8'd4;
        end else if (bus_wr) begin
            case (reg_off)
                16'd0:   thresh_low  <= bus_wdata[W-1:0];
                16'd1:   thresh_high <= bus_wdata[W-1:0];
                16'd2:   holdoff     <= bus_wdata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        obus = 16'd0;
        if (bus_rd) begin
            case (reg_off)
                16'd0:   obus = 16'(thresh_low);
                16'd1:   obus = 16'(thresh_high);
                16'd2:   obus = {8'd0, holdoff};
                16'd3:   obus = trig_cnt;
                16'd4:   obus = pileup_cnt;
                16'd5:   obus = reject_cnt;
                default: obus = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            single     <= 1'b0;
            offset     <= '0;
            coarse     <= '0;
            energy     <= '0;
            pileup     <= 1'b0;
            trig_cnt   <= '0;
            pileup_cnt <= '0;
            reject_cnt <= '0;
            peak_val   <= '0;
            level      <= '0;
            den        <= '0;
            rem        <= '0;
            quo        <= '0;
            dcnt       <= '0;
            idx        <= '0;
            coarse_lat <= '0;
            hold_lat   <= '0;
            hcnt       <= '0;
            flag       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= '0;
                snap[k] <= '0;
            end
        end else begin
            hist[0] <= data_in;
            for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];

            single <= 1'b0;
            offset <= '0;
            coarse <= '0;
            energy <= '0;
            pileup <= 1'b0;

            if (peak && state != IDLE) pileup_cnt <= sat_inc(pileup_cnt);

            case (state)
                IDLE: begin
                    if (peak) begin
                        if (hist[1] > thresh_high) begin
                            reject_cnt <= sat_inc(reject_cnt);
                        end else begin
                            for (int k = 0; k < DEPTH; k++) snap[k] <= hist[k];
                            peak_val <= hist[1];
                            level    <= hist[1] >> FRAC_SHIFT;
                            idx      <= CW'(1);
                            flag     <= 1'b0;
                            hold_lat <= holdoff;
                            state    <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (peak) flag <= 1'b1;
                    if (snap[idx] > level && snap[idx_next] <= level) begin
                        rem        <= {6'd0, level - snap[idx_next]};
                        den        <= snap[idx] - snap[idx_next];
                        coarse_lat <= idx;
                        quo        <= '0;
                        dcnt       <= '0;
                        state      <= DIVIDE;
                    end else if (idx_next == LAST_IDX) begin
                        reject_cnt <= sat_inc(reject_cnt);
                        hcnt       <= hold_lat;
                        state      <= HOLDOFF;
                    end else begin
                        idx <= idx_next;
                    end
                end
                DIVIDE: begin
                    if (peak) flag <= 1'b1;
                    rem  <= rem_ge ? rem_shift - {6'd0, den} : rem_shift;
                    quo  <= {quo[4:0], rem_ge};
                    dcnt <= dcnt + 3'd1;
                    if (dcnt == 3'd5) state <= EMIT;
                end
                EMIT: begin
                    // 6'h3F is reserved, so a full-scale fraction is pulled back by one
                    single   <= 1'b1;
                    offset   <= (quo == 6'h3F) ? 6'h3E : quo;
                    coarse   <= coarse_lat;
                    energy   <= peak_val;
                    pileup   <= flag;
                    trig_cnt <= sat_inc(trig_cnt);
                    hcnt     <= hold_lat;
                    state    <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (hcnt <= 8'd1) state <= IDLE;
                    else              hcnt  <= hcnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
